rv32im_muldiv_unit: RTL

- Iterative, multi-cycle M-extension execute unit: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside rv32i_alu in the EX stage of the pipelined RV32IM core. The pipeline issues an op on a valid/ready handshake, stalls until o_valid, then forwards o_result to the write-back path.
- Width is parametrised. Uses shift-add multiply and restoring divide at one bit per cycle, with fast paths for divide corner cases.

---
 rtl/rv32im_muldiv_pkg.sv | 34 +++
 rtl/rv32im_sign_fix.sv | 17 +
 rtl/rv32im_muldiv_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/rv32im_muldiv_pkg.sv
// Shared definitions for the RV32IM multiply/divide unit.
//   - funct3 encodings of the M-extension ops
//   - muldiv_state_t: control FSM states
//   - is_div / a_signed / b_signed: per-op decode helpers
package rv32im_muldiv_pkg;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    function automatic logic is_div(input logic [2:0] f3);
        return f3 inside {DIV, DIVU, REM, REMU};
    endfunction

    function automatic logic a_signed(input logic [2:0] f3);
        return f3 inside {MUL, MULH, MULHSU, DIV, REM};
    endfunction

    function automatic logic b_signed(input logic [2:0] f3);
        return f3 inside {MUL, MULH, DIV, REM};
    endfunction

endpackage

// File: rtl/rv32im_sign_fix.sv
// Conditional two's-complement negation.
//   i_val : value to fix up
//   i_neg : 1 = negate, 0 = pass through
//   o_val : i_neg ? -i_val : i_val
module rv32im_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val
);

    always_comb begin
        o_val = i_neg ? (~i_val + 1'b1) : i_val;
    end

endmodule

// File: rtl/rv32im_muldiv_unit.sv
// Iterative M-extension execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Shift-add multiply and restoring divide, one bit per cycle, on operand
// magnitudes; the sign is restored on the registered result in DONE.
//   clk, rst           : clock (rising edge), asynchronous active-high reset
//   i_valid, o_ready   : request handshake; accepted when both high and no flush
//   i_funct3           : op select
//   i_rs1_data/rs2     : operand a / operand b
//   i_flush            : abort whatever is in flight
//   o_valid            : one-cycle pulse, o_result valid
//   o_result           : result, held until the next o_valid
module rv32im_muldiv_unit
    import rv32im_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [2:0]       i_funct3,
    input  logic [WIDTH-1:0] i_rs1_data,
    input  logic [WIDTH-1:0] i_rs2_data,
    input  logic             i_flush,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result
);

    localparam int CW = $clog2(WIDTH);

    muldiv_state_t    state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0] hi_q, hi_d;          // product high half / remainder
    logic [WIDTH-1:0] lo_q, lo_d;          // multiplier -> product low / quotient
    logic [WIDTH-1:0] result_q, result_d;
    logic             neg_q, neg_d;        // final result must be negated

    // Operand decode at accept time
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             div_zero, div_ovf, accept;

    assign a_neg = a_signed(i_funct3) & i_rs1_data[WIDTH-1];
    assign b_neg = b_signed(i_funct3) & i_rs2_data[WIDTH-1];

    rv32im_sign_fix #(.WIDTH(WIDTH)) u_fix_a (
        .i_val (i_rs1_data),
        .i_neg (a_neg),
        .o_val (a_mag)
    );

    rv32im_sign_fix #(.WIDTH(WIDTH)) u_fix_b (
        .i_val (i_rs2_data),
        .i_neg (b_neg),
        .o_val (b_mag)
    );

    assign div_zero = (i_rs2_data == '0);
    assign div_ovf  = (i_funct3 == DIV || i_funct3 == REM)
                    && (i_rs1_data == {1'b1, {(WIDTH-1){1'b0}}})
                    && (i_rs2_data == '1);
    assign accept   = i_valid && (state_q == IDLE) && !i_flush;

    // Multiply step: conditional add into the high half, then shift {hi,lo} right
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);

    // Divide step: shift next dividend bit into the remainder, trial subtract.
    // The remainder is always below the divisor, so bit WIDTH of the
    // difference is a clean borrow flag.
    logic [WIDTH:0] div_shift, div_diff;
    logic           div_ge;
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_ge    = ~div_diff[WIDTH];

    // Result sign correction
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   div_sel, div_fixed, done_result;

    rv32im_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
        .i_val ({hi_q, lo_q}),
        .i_neg (neg_q),
        .o_val (prod_fixed)
    );

    assign div_sel = (funct3_q == REM || funct3_q == REMU) ? hi_q : lo_q;

    rv32im_sign_fix #(.WIDTH(WIDTH)) u_fix_div (
        .i_val (div_sel),
        .i_neg (neg_q),
        .o_val (div_fixed)
    );

    always_comb begin
        case (funct3_q)
            MUL:                 done_result = prod_fixed[WIDTH-1:0];
            MULH, MULHSU, MULHU: done_result = prod_fixed[2*WIDTH-1:WIDTH];
            default:             done_result = div_fixed;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        funct3_d = funct3_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        neg_d    = neg_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    funct3_d = i_funct3;
                    count_d  = '0;
                    if (is_div(i_funct3)) begin
                        // Fast paths load the final quotient/remainder directly
                        if (div_zero) begin
                            hi_d    = i_rs1_data;
                            lo_d    = '1;
                            neg_d   = 1'b0;
                            state_d = DONE;
                        end else if (div_ovf) begin
                            hi_d    = '0;
                            lo_d    = i_rs1_data;
                            neg_d   = 1'b0;
                            state_d = DONE;
                        end else begin
                            hi_d    = '0;
                            lo_d    = a_mag;
                            opnd_d  = b_mag;
                            neg_d   = (i_funct3 == REM || i_funct3 == REMU) ? a_neg
                                                                            : (a_neg ^ b_neg);
                            state_d = BUSY;
                        end
                    end else begin
                        hi_d    = '0;
                        lo_d    = b_mag;
                        opnd_d  = a_mag;
                        neg_d   = a_neg ^ b_neg;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (is_div(funct3_q)) begin
                    hi_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], div_ge};
                end else begin
                    hi_d = mul_sum[WIDTH:1];
                    lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                end
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            DONE: begin
                // Result already presented this cycle, so it is kept even on flush
                result_d = done_result;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (i_flush) begin
            state_d = IDLE;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            funct3_q <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            funct3_q <= funct3_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            neg_q    <= neg_d;
        end
    end

    assign o_ready  = (state_q == IDLE);
    assign o_valid  = (state_q == DONE);
    assign o_result = (state_q == DONE) ? done_result : result_q;

endmodule
